// File: rtl/fb_glyph_blitter.sv
// Dirty-tracked glyph scheduler: redraws changed character cells by streaming
// font-ROM rows into the framebuffer write port under a grant handshake.
module fb_glyph_blitter #(
  parameter int NUM_DIGITS = 4,
  parameter int CODE_W     = 7,
  parameter int GLYPH_ROWS = 16,
  parameter int FB_STRIDE  = 40,
  parameter int CELL_PITCH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DIGITS*CODE_W-1:0] digit_code,
  input  logic                         refresh_req,
  output logic [ADDR_W-1:0]            font_addr,
  input  logic [7:0]                   font_data,
  output logic                         fb_we,
  output logic [ADDR_W-1:0]            fb_waddr,
  output logic [7:0]                   fb_wdata,
  input  logic                         fb_grant,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int ROW_W = (GLYPH_ROWS > 1) ? $clog2(GLYPH_ROWS) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_ROWS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, FETCH, WRITE} state_t;

  state_t                state, state_n;
  logic [NUM_DIGITS-1:0] dirty, dirty_n, dirty_clr;
  logic [CODE_W-1:0]     code   [NUM_DIGITS];
  logic [CODE_W-1:0]     last   [NUM_DIGITS];
  logic [CODE_W-1:0]     last_n [NUM_DIGITS];
  logic [CODE_W-1:0]     cur_code, cur_code_n;
  logic [DIG_W-1:0]      cur_digit, cur_digit_n, pick;
  logic                  pick_valid;
  logic [ROW_W-1:0]      row, row_n, next_row;
  logic [ADDR_W-1:0]     font_addr_n, fb_waddr_n, font_base;
  logic [7:0]            fb_wdata_n;
  logic                  fb_we_n, frame_done_n, last_done;

  always_comb begin
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      code[d] = digit_code[d*CODE_W +: CODE_W];
  end

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (dirty[d] && !pick_valid) begin
        pick       = DIG_W'(d);
        pick_valid = 1'b1;
      end
    end
  end

  assign font_base = ADDR_W'(cur_code) * ADDR_W'(GLYPH_ROWS);
  assign next_row  = row + 1'b1;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n      = state;
    row_n        = row;
    cur_digit_n  = cur_digit;
    cur_code_n   = cur_code;
    font_addr_n  = font_addr;
    fb_waddr_n   = fb_waddr;
    fb_wdata_n   = fb_wdata;
    fb_we_n      = fb_we;
    dirty_clr    = '0;
    last_done    = 1'b0;
    frame_done_n = 1'b0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      last_n[d] = last[d];

    // font_addr is loaded on entry to ISSUE so the synchronous ROM samples it
    // at the end of ISSUE and its data is ready to register during FETCH.
    case (state)
      IDLE: begin
        if (pick_valid) begin
          cur_digit_n     = pick;
          cur_code_n      = code[pick];
          last_n[pick]    = code[pick];
          dirty_clr[pick] = 1'b1;
          row_n           = '0;
          font_addr_n     = ADDR_W'(code[pick]) * ADDR_W'(GLYPH_ROWS);
          state_n         = ISSUE;
        end
      end
      ISSUE: state_n = FETCH;
      FETCH: begin
        fb_wdata_n = font_data;
        fb_waddr_n = ADDR_W'(cur_digit) * ADDR_W'(CELL_PITCH)
                   + ADDR_W'(row) * ADDR_W'(FB_STRIDE);
        fb_we_n    = 1'b1;
        state_n    = WRITE;
      end
      WRITE: begin
        if (fb_grant) begin
          fb_we_n = 1'b0;
          if (row == LAST_ROW) begin
            last_done = 1'b1;
            state_n   = IDLE;
          end else begin
            row_n       = next_row;
            font_addr_n = font_base + ADDR_W'(next_row);
            state_n     = ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Mismatch is taken against the post-latch value so the picked digit's own
    // change is consumed, while a refresh in the same cycle keeps it dirty.
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      dirty_n[d] = (dirty[d] & ~dirty_clr[d]) | refresh_req | (code[d] != last_n[d]);

    frame_done_n = last_done && (dirty_n == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirty      <= '1;
      cur_code   <= '0;
      cur_digit  <= '0;
      row        <= '0;
      font_addr  <= '0;
      fb_we      <= 1'b0;
      fb_waddr   <= '0;
      fb_wdata   <= '0;
      frame_done <= 1'b0;
      for (int unsigned d = 0; d < NUM_DIGITS; d++)
        last[d] <= '1;
    end else begin
      dirty      <= dirty_n;
      cur_code   <= cur_code_n;
      cur_digit  <= cur_digit_n;
      row        <= row_n;
      font_addr  <= font_addr_n;
      fb_we      <= fb_we_n;
      fb_waddr   <= fb_waddr_n;
      fb_wdata   <= fb_wdata_n;
      frame_done <= frame_done_n;
      for (int unsigned d = 0; d < NUM_DIGITS; d++)
        last[d] <= last_n[d];
    end
  end

endmodule

// File: tb/tb_fb_glyph_blitter.sv
// Directed bench for fb_glyph_blitter with a synchronous font ROM model and a
// write-port monitor logging every accepted framebuffer write.
module tb_fb_glyph_blitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] digit_code;
  logic        refresh_req;
  logic [31:0] font_addr;
  logic [7:0]  font_data;
  logic        fb_we;
  logic [31:0] fb_waddr;
  logic [7:0]  fb_wdata;
  logic        fb_grant;
  logic        busy;
  logic        frame_done;

  logic [6:0]  codes [4];
  int          total = 0;
  int          bad   = 0;

  logic [31:0] wa [$];
  logic [7:0]  wd [$];
  logic [31:0] ea [$];
  logic [7:0]  ed [$];
  int          done_cnt = 0;
  int          done_at  = -1;

  assign digit_code = {codes[3], codes[2], codes[1], codes[0]};

  always #5 clk = ~clk;

  fb_glyph_blitter #(
    .NUM_DIGITS(4), .CODE_W(7), .GLYPH_ROWS(16),
    .FB_STRIDE(40), .CELL_PITCH(2), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .digit_code(digit_code), .refresh_req(refresh_req),
    .font_addr(font_addr), .font_data(font_data), .fb_we(fb_we),
    .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_grant(fb_grant),
    .busy(busy), .frame_done(frame_done)
  );

  function automatic logic [7:0] rom_f(input int unsigned a);
    return 8'((a * 37 + 11) ^ (a >> 4));
  endfunction

  always @(posedge clk) font_data <= rom_f(int'(font_addr[10:0]));

  always @(negedge clk) begin
    if (!rst && fb_we && fb_grant) begin
      wa.push_back(fb_waddr);
      wd.push_back(fb_wdata);
    end
    if (frame_done) begin
      done_cnt++;
      done_at = wa.size();
    end
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); ea.delete(); ed.delete();
    done_cnt = 0;
    done_at  = -1;
  endtask

  task automatic exp_cell(input int d, input int c);
    for (int r = 0; r < 16; r++) begin
      ea.push_back(32'(d * 2 + r * 40));
      ed.push_back(rom_f(c * 16 + r));
    end
  endtask

  task automatic wait_quiet(input int budget, output bit to);
    int q = 0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) q++; else q = 0;
      if (q >= 8) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_point(input logic [31:0] addr, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (fb_we && fb_waddr == addr) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; refresh_req = 1'b0; fb_grant = 1'b1;
    codes[0] = 7'd0; codes[1] = 7'd1; codes[2] = 7'd2; codes[3] = 7'd3;
    repeat (2) @(posedge clk);
    #1;
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", fb_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
    total++; if (font_addr !== 32'd0) begin bad++; $display("FAIL reset_font_addr got=%0d want=0", font_addr); end
    total++; if (fb_waddr !== 32'd0 || fb_wdata !== 8'd0) begin
      bad++; $display("FAIL reset_wport got=%0d/%02h want=0/00", fb_waddr, fb_wdata);
    end
  endtask

  task automatic test_first_frame();
    bit to;
    clear_log();
    for (int d = 0; d < 4; d++) exp_cell(d, d);
    rst = 1'b0;
    wait_quiet(800, to);
    total++; if (to) begin bad++; $display("FAIL first_frame timeout got=busy want=idle"); end
    total++; if (wa.size() != ea.size()) begin bad++; $display("FAIL first_frame count got=%0d want=%0d", wa.size(), ea.size()); end
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        bad++; $display("FAIL first_frame w%0d got=%0d/%02h want=%0d/%02h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
    total++; if (wa.size() == 64 && wa[63] !== 32'd606) begin bad++; $display("FAIL first_frame last_addr got=%0d want=606", wa[63]); end
    total++; if (done_cnt != 1 || done_at != 64) begin bad++; $display("FAIL first_frame done got=%0d@%0d want=1@64", done_cnt, done_at); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_frame busy got=%b want=0", busy); end
  endtask

  task automatic test_single_change();
    bit to;
    clear_log();
    exp_cell(2, 10);
    @(posedge clk); #1;
    codes[2] = 7'hA;
    wait_quiet(400, to);
    total++; if (to) begin bad++; $display("FAIL single_change timeout got=busy want=idle"); end
    total++; if (wa.size() != 16) begin bad++; $display("FAIL single_change count got=%0d want=16", wa.size()); end
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        bad++; $display("FAIL single_change w%0d got=%0d/%02h want=%0d/%02h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_change done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_grant_stall();
    bit to;
    logic [31:0] a;
    logic [7:0]  dv;
    clear_log();
    exp_cell(1, 5);
    @(posedge clk); #1;
    codes[1] = 7'd5;
    wait_point(32'd202, 400, to);
    total++; if (to) begin bad++; $display("FAIL stall_reach timeout got=none want=row5"); end
    fb_grant = 1'b0;
    a  = fb_waddr;
    dv = fb_wdata;
    total++; if (dv !== rom_f(5 * 16 + 5)) begin bad++; $display("FAIL stall_data got=%02h want=%02h", dv, rom_f(85)); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (fb_we !== 1'b1 || fb_waddr !== a || fb_wdata !== dv) begin
        bad++; $display("FAIL stall_hold c%0d got=%b/%0d/%02h want=1/%0d/%02h", i, fb_we, fb_waddr, fb_wdata, a, dv);
      end
    end
    total++; if (wa.size() != 5) begin bad++; $display("FAIL stall_no_accept got=%0d want=5", wa.size()); end
    fb_grant = 1'b1;
    wait_quiet(400, to);
    total++; if (to) begin bad++; $display("FAIL stall_end timeout got=busy want=idle"); end
    total++; if (wa.size() != 16) begin bad++; $display("FAIL stall_count got=%0d want=16", wa.size()); end
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        bad++; $display("FAIL stall w%0d got=%0d/%02h want=%0d/%02h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_midblit_change();
    bit to;
    clear_log();
    exp_cell(0, 7);
    exp_cell(0, 12);
    @(posedge clk); #1;
    codes[0] = 7'd7;
    wait_point(32'd280, 400, to);
    total++; if (to) begin bad++; $display("FAIL midblit_reach timeout got=none want=row7"); end
    codes[0] = 7'hC;
    wait_quiet(600, to);
    total++; if (to) begin bad++; $display("FAIL midblit_end timeout got=busy want=idle"); end
    total++; if (wa.size() != 32) begin bad++; $display("FAIL midblit_count got=%0d want=32", wa.size()); end
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        bad++; $display("FAIL midblit w%0d got=%0d/%02h want=%0d/%02h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
    total++; if (done_cnt != 1 || done_at != 32) begin bad++; $display("FAIL midblit_done got=%0d@%0d want=1@32", done_cnt, done_at); end
  endtask

  task automatic test_refresh();
    bit to;
    clear_log();
    exp_cell(0, 12); exp_cell(1, 5); exp_cell(2, 10); exp_cell(3, 3);
    @(posedge clk); #1;
    refresh_req = 1'b1;
    @(posedge clk); #1;
    refresh_req = 1'b0;
    wait_quiet(800, to);
    total++; if (to) begin bad++; $display("FAIL refresh timeout got=busy want=idle"); end
    total++; if (wa.size() != 64) begin bad++; $display("FAIL refresh_count got=%0d want=64", wa.size()); end
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        bad++; $display("FAIL refresh w%0d got=%0d/%02h want=%0d/%02h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
    total++; if (done_cnt != 1 || done_at != 64) begin bad++; $display("FAIL refresh_done got=%0d@%0d want=1@64", done_cnt, done_at); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    clear_log();
    @(posedge clk); #1;
    refresh_req = 1'b1;
    @(posedge clk); #1;
    refresh_req = 1'b0;
    wait_point(32'd362, 400, to);
    total++; if (to) begin bad++; $display("FAIL rstmid_reach timeout got=none want=d1row9"); end
    rst = 1'b1;
    #1;
    total++; if (fb_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_now got=%b/%b want=0/0", fb_we, busy); end
    n = wa.size();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (fb_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_hold c%0d got=%b/%b want=0/0", i, fb_we, busy); end
    end
    total++; if (wa.size() != n) begin bad++; $display("FAIL rstmid_nowrite got=%0d want=%0d", wa.size(), n); end
    clear_log();
    exp_cell(0, 12); exp_cell(1, 5); exp_cell(2, 10); exp_cell(3, 3);
    rst = 1'b0;
    wait_quiet(800, to);
    total++; if (to) begin bad++; $display("FAIL rstmid_end timeout got=busy want=idle"); end
    total++; if (wa.size() != 64) begin bad++; $display("FAIL rstmid_count got=%0d want=64", wa.size()); end
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        bad++; $display("FAIL rstmid w%0d got=%0d/%02h want=%0d/%02h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rstmid_done got=%0d want=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_single_change();
    test_grant_stall();
    test_midblit_change();
    test_refresh();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
